mem_ctl: RTL and testbench

//  Memory-access controller: the responder side of the din/dout four-phase handshake.

---
 rtl/mem_ctl_pkg.sv | 23 ++
 rtl/mem_ctl_timeout.sv | 30 +++
 rtl/mem_ctl.sv | 119 +++++++++++
 tb/tb_mem_ctl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_ctl_pkg.sv
// Shared state encodings for the memory-access controller.
// The 4-bit values are visible on state_dbg, so they must not be renumbered.
package mem_ctl_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WR_REQ     = 4'd1,
        WR_ACK     = 4'd2,
        WR_REL     = 4'd3,
        RD_OUT     = 4'd4,
        RD_ACK     = 4'd5,
        RD_REQ     = 4'd7,
        RD_OUT_REL = 4'd12,
        RD_REL     = 4'd13,
        ERR        = 4'd15
    } state_t;

    // States in which the controller waits on a mem_done edge and may time out.
    function automatic logic is_timed(input state_t s);
        return (s == WR_REQ) || (s == WR_REL) || (s == RD_REQ) || (s == RD_REL);
    endfunction

endpackage

// File: rtl/mem_ctl_timeout.sv
// Saturating wait-cycle counter; expired flags the last allowed cycle in a state.
// TIMEOUT=0 keeps expired low permanently.
module mem_ctl_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Counting from zero, the state is left after exactly TIMEOUT cycles in it.
    assign expired = (TIMEOUT != 0) && en && (cnt_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_ctl.sv
// Responder side of the host four-phase handshake, driving memory write/read strobes
// and returning read data over dout_valid/dout_ack. All outputs decode from registers.
module mem_ctl
    import mem_ctl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic              wen,
    input  logic [ADDR_W-1:0] din_addr,
    input  logic [DATA_W-1:0] din_data,
    output logic              din_ack,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              dout_valid,
    input  logic              dout_ack,
    output logic [DATA_W-1:0] dout,
    output logic              err,
    output logic [3:0]        state_dbg
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              err_reg;
    logic              expired;

    mem_ctl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_next != state_reg),
        .en      (is_timed(state_reg)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Only the current state's own exit condition is looked at; a completion edge
    // takes precedence over a timeout in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (din_valid) state_next = wen ? WR_REQ : RD_REQ;
            WR_REQ:     if (mem_done) state_next = WR_REL;
                        else if (expired) state_next = ERR;
            WR_REL:     if (!mem_done) state_next = WR_ACK;
                        else if (expired) state_next = ERR;
            WR_ACK:     if (!din_valid) state_next = IDLE;
            RD_REQ:     if (mem_done) state_next = RD_ACK;
                        else if (expired) state_next = ERR;
            RD_ACK:     if (!din_valid) state_next = RD_OUT;
            RD_OUT:     if (dout_ack) state_next = RD_OUT_REL;
            RD_OUT_REL: if (!dout_ack) state_next = RD_REL;
            RD_REL:     if (!mem_done) state_next = IDLE;
                        else if (expired) state_next = ERR;
            ERR:        if (!din_valid) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        write      = 1'b0;
        read       = 1'b0;
        din_ack    = 1'b0;
        dout_valid = 1'b0;
        case (state_reg)
            WR_REQ:     write = 1'b1;
            WR_ACK:     din_ack = 1'b1;
            RD_REQ:     read = 1'b1;
            RD_ACK:     begin read = 1'b1; din_ack = 1'b1; end
            RD_OUT:     begin read = 1'b1; dout_valid = 1'b1; end
            RD_OUT_REL: read = 1'b1;
            ERR:        din_ack = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            dout_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && din_valid) begin
                addr_reg  <= din_addr;
                wdata_reg <= din_data;
            end
            if (state_reg == RD_REQ && mem_done) begin
                dout_reg <= mem_rdata;
            end
            if (state_next == ERR) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign dout      = dout_reg;
    assign err       = err_reg;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_mem_ctl.sv
// Directed bench for mem_ctl: a vector table for the write/read/back-to-back flows,
// then hand sequences for timeout and asynchronous reset.
module tb_mem_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_valid, wen, mem_done, dout_ack;
    logic [7:0] din_addr, din_data, mem_rdata;
    logic       din_ack, write, read, dout_valid, err;
    logic [7:0] mem_addr, mem_wdata, dout;
    logic [3:0] state_dbg;

    int pass_cnt = 0;
    int total    = 0;

    mem_ctl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .wen        (wen),
        .din_addr   (din_addr),
        .din_data   (din_data),
        .din_ack    (din_ack),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .write      (write),
        .read       (read),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dout_valid (dout_valid),
        .dout_ack   (dout_ack),
        .dout       (dout),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Output bundle: {state, write, read, din_ack, dout_valid, err, dout, mem_addr, mem_wdata}
    typedef logic [32:0] obs_t;

    typedef struct {
        logic       dv;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       md;
        logic [7:0] rdata;
        logic       dack;
        obs_t       exp;
    } vec_t;

    function automatic obs_t mk(input logic [3:0] st, input logic w, input logic r,
                                input logic da, input logic dov, input logic e,
                                input logic [7:0] d, input logic [7:0] ma,
                                input logic [7:0] wd);
        return {st, w, r, da, dov, e, d, ma, wd};
    endfunction

    function automatic obs_t observe();
        return {state_dbg, write, read, din_ack, dout_valid, err, dout, mem_addr, mem_wdata};
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = observe();
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic dv, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic md, input logic [7:0] rd,
                         input logic dack);
        din_valid = dv; wen = we; din_addr = a; din_data = d;
        mem_done = md; mem_rdata = rd; dout_ack = dack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[25];

    initial begin
        // inputs applied, then state/outputs expected after the next rising edge
        vecs[0]  = '{1, 1, 8'h3C, 8'hA5, 0, 8'h00, 0, mk(4'd1,  1,0,0,0,0, 8'h00, 8'h3C, 8'hA5)};
        vecs[1]  = '{1, 1, 8'h3C, 8'hA5, 0, 8'h00, 0, mk(4'd1,  1,0,0,0,0, 8'h00, 8'h3C, 8'hA5)};
        vecs[2]  = '{1, 1, 8'h3C, 8'hA5, 1, 8'h00, 0, mk(4'd3,  0,0,0,0,0, 8'h00, 8'h3C, 8'hA5)};
        vecs[3]  = '{1, 1, 8'h3C, 8'hA5, 0, 8'h00, 0, mk(4'd2,  0,0,1,0,0, 8'h00, 8'h3C, 8'hA5)};
        vecs[4]  = '{1, 0, 8'h3C, 8'hA5, 0, 8'h00, 0, mk(4'd2,  0,0,1,0,0, 8'h00, 8'h3C, 8'hA5)};
        vecs[5]  = '{0, 0, 8'hFF, 8'hFF, 0, 8'h00, 0, mk(4'd0,  0,0,0,0,0, 8'h00, 8'h3C, 8'hA5)};
        vecs[6]  = '{0, 0, 8'hEE, 8'hEE, 0, 8'h00, 0, mk(4'd0,  0,0,0,0,0, 8'h00, 8'h3C, 8'hA5)};
        vecs[7]  = '{1, 0, 8'h81, 8'h00, 0, 8'h00, 0, mk(4'd7,  0,1,0,0,0, 8'h00, 8'h81, 8'h00)};
        vecs[8]  = '{1, 0, 8'h81, 8'h00, 1, 8'h5A, 0, mk(4'd5,  0,1,1,0,0, 8'h5A, 8'h81, 8'h00)};
        vecs[9]  = '{0, 1, 8'h81, 8'h00, 1, 8'h00, 0, mk(4'd4,  0,1,0,1,0, 8'h5A, 8'h81, 8'h00)};
        vecs[10] = '{0, 1, 8'h81, 8'h00, 1, 8'h00, 1, mk(4'd12, 0,1,0,0,0, 8'h5A, 8'h81, 8'h00)};
        vecs[11] = '{0, 0, 8'h81, 8'h00, 1, 8'h00, 0, mk(4'd13, 0,0,0,0,0, 8'h5A, 8'h81, 8'h00)};
        vecs[12] = '{0, 0, 8'h81, 8'h00, 0, 8'h00, 0, mk(4'd0,  0,0,0,0,0, 8'h5A, 8'h81, 8'h00)};
        vecs[13] = '{1, 1, 8'h10, 8'h77, 0, 8'h00, 0, mk(4'd1,  1,0,0,0,0, 8'h5A, 8'h10, 8'h77)};
        vecs[14] = '{1, 0, 8'h10, 8'h77, 1, 8'h00, 0, mk(4'd3,  0,0,0,0,0, 8'h5A, 8'h10, 8'h77)};
        vecs[15] = '{1, 0, 8'h10, 8'h77, 0, 8'h00, 0, mk(4'd2,  0,0,1,0,0, 8'h5A, 8'h10, 8'h77)};
        vecs[16] = '{0, 0, 8'h10, 8'h77, 0, 8'h00, 0, mk(4'd0,  0,0,0,0,0, 8'h5A, 8'h10, 8'h77)};
        vecs[17] = '{1, 0, 8'h22, 8'h99, 0, 8'h00, 0, mk(4'd7,  0,1,0,0,0, 8'h5A, 8'h22, 8'h99)};
        vecs[18] = '{0, 0, 8'h22, 8'h99, 1, 8'hC3, 0, mk(4'd5,  0,1,1,0,0, 8'hC3, 8'h22, 8'h99)};
        vecs[19] = '{0, 0, 8'h22, 8'h99, 1, 8'h00, 0, mk(4'd4,  0,1,0,1,0, 8'hC3, 8'h22, 8'h99)};
        vecs[20] = '{0, 0, 8'h22, 8'h99, 0, 8'h00, 0, mk(4'd4,  0,1,0,1,0, 8'hC3, 8'h22, 8'h99)};
        vecs[21] = '{0, 0, 8'h22, 8'h99, 0, 8'h00, 1, mk(4'd12, 0,1,0,0,0, 8'hC3, 8'h22, 8'h99)};
        vecs[22] = '{0, 0, 8'h22, 8'h99, 1, 8'h00, 0, mk(4'd13, 0,0,0,0,0, 8'hC3, 8'h22, 8'h99)};
        vecs[23] = '{0, 0, 8'h22, 8'h99, 1, 8'h00, 0, mk(4'd13, 0,0,0,0,0, 8'hC3, 8'h22, 8'h99)};
        vecs[24] = '{0, 0, 8'h22, 8'h99, 0, 8'h00, 0, mk(4'd0,  0,0,0,0,0, 8'hC3, 8'h22, 8'h99)};

        rst_n = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        #1;
        check("reset_async", mk(4'd0, 0,0,0,0,0, 8'h00, 8'h00, 8'h00));
        tick();
        tick();
        check("reset_hold", mk(4'd0, 0,0,0,0,0, 8'h00, 8'h00, 8'h00));
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].dv, vecs[i].we, vecs[i].addr, vecs[i].data,
                  vecs[i].md, vecs[i].rdata, vecs[i].dack);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Timeout: write with mem_done held low; WR_REQ lasts exactly 4 cycles.
        drive(1, 1, 8'h55, 8'h66, 0, 8'h00, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("to_wait%0d", c), mk(4'd1, 1,0,0,0,0, 8'hC3, 8'h55, 8'h66));
        end
        tick();
        check("to_err", mk(4'd15, 0,0,1,0,1, 8'hC3, 8'h55, 8'h66));
        tick();
        check("to_err_hold", mk(4'd15, 0,0,1,0,1, 8'hC3, 8'h55, 8'h66));
        drive(0, 1, 8'h55, 8'h66, 0, 8'h00, 0);
        tick();
        check("to_idle_sticky", mk(4'd0, 0,0,0,0,1, 8'hC3, 8'h55, 8'h66));

        // Reset in RD_OUT: outputs clear before any clock edge.
        drive(1, 0, 8'h44, 8'h00, 0, 8'h00, 0);
        tick();
        drive(1, 0, 8'h44, 8'h00, 1, 8'hB7, 0);
        tick();
        drive(0, 0, 8'h44, 8'h00, 1, 8'h00, 0);
        tick();
        check("rst_pre_rd_out", mk(4'd4, 0,1,0,1,1, 8'hB7, 8'h44, 8'h00));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_read", mk(4'd0, 0,0,0,0,0, 8'h00, 8'h00, 8'h00));
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 1, 8'h9A, 8'h3E, 0, 8'h00, 0);
        tick();
        check("post_rst_wr_req", mk(4'd1, 1,0,0,0,0, 8'h00, 8'h9A, 8'h3E));
        drive(1, 1, 8'h9A, 8'h3E, 1, 8'h00, 0);
        tick();
        check("post_rst_wr_rel", mk(4'd3, 0,0,0,0,0, 8'h00, 8'h9A, 8'h3E));
        drive(1, 1, 8'h9A, 8'h3E, 0, 8'h00, 0);
        tick();
        check("post_rst_wr_ack", mk(4'd2, 0,0,1,0,0, 8'h00, 8'h9A, 8'h3E));
        drive(0, 1, 8'h9A, 8'h3E, 0, 8'h00, 0);
        tick();
        check("post_rst_idle", mk(4'd0, 0,0,0,0,0, 8'h00, 8'h9A, 8'h3E));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
